// File: rtl/sap_datapath_if.sv
// SAP-1 datapath bundle: control word and program-load port in, status out.
// Latency: n/a (wires only).
// Backpressure: none; the control word is applied every cycle it is present.
//
// Signals (master = sequencer / loader side, slave = datapath side):
//   cbus        16-bit control word from the sequencer
//   prog_we     RAM program write strobe
//   prog_addr   RAM program write address
//   prog_data   RAM program write data
//   instruction opcode (IR[7:4]) back to the sequencer
//   out_value   output register
//   out_valid   one-cycle pulse after an output latch
//   carry/zero  ALU flags
//   halted      sticky halt status
//   bus_err     sticky multiple-driver flag
//   bus_value   combinational shared-bus value (debug)
interface sap_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [15:0]       cbus;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [3:0]        instruction;
    logic [DATA_W-1:0] out_value;
    logic              out_valid;
    logic              carry;
    logic              zero;
    logic              halted;
    logic              bus_err;
    logic [DATA_W-1:0] bus_value;

    modport master (
        output cbus, prog_we, prog_addr, prog_data,
        input  instruction, out_value, out_valid, carry, zero,
               halted, bus_err, bus_value
    );

    modport slave (
        input  cbus, prog_we, prog_addr, prog_data,
        output instruction, out_value, out_valid, carry, zero,
               halted, bus_err, bus_value
    );
endinterface

// File: rtl/sap_datapath.sv
// SAP-1 datapath: shared bus, PC, MAR, 16x8 RAM, IR, A, B, ALU, output reg.
// Latency: bus/ALU combinational; all register transfers land at the next edge.
// Backpressure: none; once halted every control bit is ignored until reset.
//
// Ports:
//   clk     system clock, all state on the rising edge
//   reset   asynchronous active-low reset (RAM contents are kept)
//   bus_if  slave side of sap_datapath_if (control word, program port, status)
module sap_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    sap_datapath_if.slave bus_if
);

    localparam int DEPTH = 2 ** ADDR_W;

    // ------------------------------------------------------------------
    // Control word decode
    // ------------------------------------------------------------------
    // Bus drivers and the ALU operation come straight from the control
    // word; they only shape combinational values and never change state.
    logic c_ro, c_io, c_ao, c_eo, c_su, c_co;
    assign c_ro = bus_if.cbus[12];
    assign c_io = bus_if.cbus[11];
    assign c_ao = bus_if.cbus[8];
    assign c_eo = bus_if.cbus[7];
    assign c_su = bus_if.cbus[6];
    assign c_co = bus_if.cbus[2];

    // Everything that updates state is masked once halted. HLT itself is
    // masked too, which is harmless since halted is already sticky.
    logic halted_q;
    logic l_hlt, l_mi, l_ri, l_ii, l_ai, l_bi, l_oi, l_ce, l_eo;
    assign l_hlt = bus_if.cbus[15] & ~halted_q;
    assign l_mi  = bus_if.cbus[14] & ~halted_q;
    assign l_ri  = bus_if.cbus[13] & ~halted_q;
    assign l_ii  = bus_if.cbus[10] & ~halted_q;
    assign l_ai  = bus_if.cbus[9]  & ~halted_q;
    assign l_bi  = bus_if.cbus[5]  & ~halted_q;
    assign l_oi  = bus_if.cbus[4]  & ~halted_q;
    assign l_ce  = bus_if.cbus[3]  & ~halted_q;
    assign l_eo  = c_eo            & ~halted_q;

    // Reserved control bits carry no meaning.
    logic unused_cbus;
    assign unused_cbus = ^bus_if.cbus[1:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] a_q,   a_d;
    logic [DATA_W-1:0] b_q,   b_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              carry_q, carry_d;
    logic              zero_q,  zero_d;
    logic              halted_d;
    logic              bus_err_q, bus_err_d;
    logic              out_vld_q, out_vld_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // ALU: always computing from the current A and B
    // ------------------------------------------------------------------
    logic [DATA_W:0]   alu_sum;
    logic [DATA_W-1:0] alu_diff;
    logic [DATA_W-1:0] alu_r;
    logic              alu_c;

    assign alu_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign alu_diff = a_q - b_q;

    always_comb begin
        alu_r = alu_sum[DATA_W-1:0];
        alu_c = alu_sum[DATA_W];
        if (c_su) begin
            alu_r = alu_diff;
            // Carry on subtract means "no borrow".
            alu_c = (a_q >= b_q);
        end
    end

    // ------------------------------------------------------------------
    // Shared bus: fixed priority RO > IO > AO > EO > CO, idle value 0
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] bus_val;
    logic [2:0]        n_drv;
    logic              multi_drv;

    always_comb begin
        bus_val = '0;
        if (c_ro) begin
            bus_val = mem[mar_q];
        end else if (c_io) begin
            bus_val = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
        end else if (c_ao) begin
            bus_val = a_q;
        end else if (c_eo) begin
            bus_val = alu_r;
        end else if (c_co) begin
            bus_val = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
        end
    end

    assign n_drv     = 3'(c_ro) + 3'(c_io) + 3'(c_ao) + 3'(c_eo) + 3'(c_co);
    assign multi_drv = (n_drv > 3'd1);

    // ------------------------------------------------------------------
    // Next state: every source is a pre-edge value, so AI|EO accumulates
    // and AI|AO is a no-op without any special casing.
    // ------------------------------------------------------------------
    always_comb begin
        pc_d      = pc_q;
        mar_d     = mar_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        out_d     = out_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        halted_d  = halted_q | l_hlt;
        bus_err_d = bus_err_q | (multi_drv & ~halted_q);
        out_vld_d = l_oi;

        if (l_mi) mar_d = bus_val[ADDR_W-1:0];
        if (l_ii) ir_d  = bus_val;
        if (l_ai) a_d   = bus_val;
        if (l_bi) b_d   = bus_val;
        if (l_oi) out_d = bus_val;
        if (l_ce) pc_d  = pc_q + 1'b1;   // natural wrap at 2**ADDR_W
        if (l_eo) begin
            carry_d = alu_c;
            zero_d  = (alu_r == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= '0;
            mar_q     <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            out_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            mar_q     <= mar_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            out_q     <= out_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            halted_q  <= halted_d;
            bus_err_q <= bus_err_d;
            out_vld_q <= out_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // RAM: no reset. The program port is written last so it wins a
    // same-address collision with RI; different addresses both land.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (l_ri) begin
            mem[mar_q] <= bus_val;
        end
        if (bus_if.prog_we) begin
            mem[bus_if.prog_addr] <= bus_if.prog_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_if.instruction = ir_q[DATA_W-1:DATA_W-4];
    assign bus_if.out_value   = out_q;
    assign bus_if.out_valid   = out_vld_q;
    assign bus_if.carry       = carry_q;
    assign bus_if.zero        = zero_q;
    assign bus_if.halted      = halted_q;
    assign bus_if.bus_err     = bus_err_q;
    assign bus_if.bus_value   = bus_val;

endmodule

// File: tb/tb_sap_datapath.sv
// Bench for sap_datapath: drives control words and program writes, checks
// register transfers through the debug bus and the status outputs.
// Expected bus/output values are queued at stimulus time and popped on compare.
module tb_sap_datapath;

    localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000,
                            RO  = 16'h1000, IO = 16'h0800, II = 16'h0400,
                            AI  = 16'h0200, AO = 16'h0100, EO = 16'h0080,
                            SU  = 16'h0040, BI = 16'h0020, OI = 16'h0010,
                            CE  = 16'h0008, CO = 16'h0004;

    logic clk;
    logic reset;

    sap_datapath_if #(.DATA_W(8), .ADDR_W(4)) ifc ();

    sap_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] sb [$];
    logic [7:0] v, e;

    // One clock with a control word (and optional program write) applied.
    task automatic cycp(input logic [15:0] cw, input logic we,
                        input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        ifc.cbus      = cw;
        ifc.prog_we   = we;
        ifc.prog_addr = a;
        ifc.prog_data = d;
        @(posedge clk);
        #1;
        ifc.cbus    = 16'h0;
        ifc.prog_we = 1'b0;
    endtask

    task automatic cyc(input logic [15:0] cw);
        cycp(cw, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic prog(input logic [3:0] a, input logic [7:0] d);
        cycp(16'h0, 1'b1, a, d);
    endtask

    // Look at the bus for a driver word without letting an edge happen.
    task automatic peek(input logic [15:0] cw, output logic [7:0] val);
        @(negedge clk);
        ifc.cbus = cw;
        #1;
        val = ifc.bus_value;
        ifc.cbus = 16'h0;
    endtask

    task automatic ce_n(input int n);
        for (int i = 0; i < n; i++) cyc(CE);
    endtask

    task automatic load_a(input logic [7:0] d);   // assumes MAR = F
        cycp(16'h0, 1'b1, 4'hF, d);
        cyc(RO | AI);
    endtask

    task automatic load_b(input logic [7:0] d);   // assumes MAR = F
        cycp(16'h0, 1'b1, 4'hF, d);
        cyc(RO | BI);
    endtask

    task automatic test_reset;
        ifc.cbus = 16'h0; ifc.prog_we = 1'b0; ifc.prog_addr = '0; ifc.prog_data = '0;
        reset = 1'b0;
        #12;
        n_chk++; if (ifc.instruction !== 4'h0) begin n_fail++; $display("FAIL rst_instr: got %h exp 0", ifc.instruction); end
        n_chk++; if (ifc.out_value !== 8'h00) begin n_fail++; $display("FAIL rst_out: got %h exp 00", ifc.out_value); end
        n_chk++; if ({ifc.out_valid, ifc.carry, ifc.zero, ifc.halted, ifc.bus_err} !== 5'b0)
            begin n_fail++; $display("FAIL rst_flags: got %b exp 00000", {ifc.out_valid, ifc.carry, ifc.zero, ifc.halted, ifc.bus_err}); end
        n_chk++; if (ifc.bus_value !== 8'h00) begin n_fail++; $display("FAIL rst_bus: got %h exp 00", ifc.bus_value); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fetch;
        prog(4'h0, 8'h00);
        prog(4'h3, 8'h5A);
        cyc(MI | CO);
        cyc(RO | II);
        n_chk++; if (ifc.instruction !== 4'h0) begin n_fail++; $display("FAIL fetch0_instr: got %h exp 0", ifc.instruction); end
        sb.push_back(8'h00); peek(IO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL fetch0_ir: got %h exp %h", v, e); end
        prog(4'h0, 8'h1E);
        cyc(MI | CO | CE);
        cyc(RO | II);
        n_chk++; if (ifc.instruction !== 4'h1) begin n_fail++; $display("FAIL fetch1_instr: got %h exp 1", ifc.instruction); end
        sb.push_back(8'h0E); peek(IO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL fetch1_ir: got %h exp %h", v, e); end
        sb.push_back(8'h01); peek(CO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL fetch1_pc: got %h exp %h", v, e); end
    endtask

    task automatic test_lda_add_out;
        prog(4'hE, 8'h1C);
        prog(4'hF, 8'h0E);
        cyc(IO | MI);
        cyc(RO | AI);
        sb.push_back(8'h1C); peek(AO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL lda_a: got %h exp %h", v, e); end
        prog(4'h2, 8'h2F);
        cyc(CE);
        cyc(CO | MI);
        cyc(RO | II);
        n_chk++; if (ifc.instruction !== 4'h2) begin n_fail++; $display("FAIL add_instr: got %h exp 2", ifc.instruction); end
        cyc(IO | MI);
        cyc(RO | BI);
        cyc(EO | AI);
        sb.push_back(8'h2A); peek(AO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL add_a: got %h exp %h", v, e); end
        n_chk++; if ({ifc.carry, ifc.zero} !== 2'b00) begin n_fail++; $display("FAIL add_flags: got %b exp 00", {ifc.carry, ifc.zero}); end
        sb.push_back(8'h2A);
        cyc(AO | OI);
        e = sb.pop_front();
        n_chk++; if (ifc.out_valid !== 1'b1 || ifc.out_value !== e)
            begin n_fail++; $display("FAIL out_pulse: got vld=%b val=%h exp vld=1 val=%h", ifc.out_valid, ifc.out_value, e); end
        cyc(16'h0);
        n_chk++; if (ifc.out_valid !== 1'b0 || ifc.out_value !== 8'h2A)
            begin n_fail++; $display("FAIL out_after: got vld=%b val=%h exp vld=0 val=2a", ifc.out_valid, ifc.out_value); end
    endtask

    task automatic test_prog_conflict;
        // MAR = F, A = 2A
        cycp(AO | RI, 1'b1, 4'hF, 8'h99);
        sb.push_back(8'h99); peek(RO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL prog_same_addr: got %h exp %h", v, e); end
        cycp(AO | RI, 1'b1, 4'h4, 8'h44);
        sb.push_back(8'h2A); peek(RO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL prog_diff_addr: got %h exp %h", v, e); end
    endtask

    task automatic test_sub;
        load_a(8'h05); load_b(8'h05);
        cyc(EO | SU | AI);
        sb.push_back(8'h00); peek(AO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL sub_eq_a: got %h exp %h", v, e); end
        n_chk++; if ({ifc.carry, ifc.zero} !== 2'b11) begin n_fail++; $display("FAIL sub_eq_flags: got %b exp 11", {ifc.carry, ifc.zero}); end
        load_a(8'h03); load_b(8'h05);
        cyc(EO | SU | AI);
        sb.push_back(8'hFE); peek(AO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL sub_borrow_a: got %h exp %h", v, e); end
        n_chk++; if ({ifc.carry, ifc.zero} !== 2'b00) begin n_fail++; $display("FAIL sub_borrow_flags: got %b exp 00", {ifc.carry, ifc.zero}); end
        load_a(8'hFF); load_b(8'h01);
        cyc(EO | AI);
        sb.push_back(8'h00); peek(AO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL add_wrap_a: got %h exp %h", v, e); end
        n_chk++; if ({ifc.carry, ifc.zero} !== 2'b11) begin n_fail++; $display("FAIL add_wrap_flags: got %b exp 11", {ifc.carry, ifc.zero}); end
        cyc(AO);
        n_chk++; if ({ifc.carry, ifc.zero} !== 2'b11) begin n_fail++; $display("FAIL flags_hold: got %b exp 11", {ifc.carry, ifc.zero}); end
    endtask

    task automatic test_pc_wrap;
        ce_n(14);                       // PC 2 -> 0
        cyc(CO | MI);                   // MAR = 0
        prog(4'h0, 8'h11);
        prog(4'hF, 8'hB7);
        sb.push_back(8'h11); peek(RO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL wrap_mar0: got %h exp %h", v, e); end
        ce_n(16);
        sb.push_back(8'h00); peek(CO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL wrap_16: got %h exp %h", v, e); end
        ce_n(15);
        sb.push_back(8'h0F); peek(CO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL wrap_15: got %h exp %h", v, e); end
        cyc(CO | CE | MI);
        sb.push_back(8'hB7); peek(RO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL coce_mar: got %h exp %h", v, e); end
        sb.push_back(8'h00); peek(CO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL coce_pc: got %h exp %h", v, e); end
    endtask

    task automatic test_conflict;
        load_a(8'h77);                  // MAR = F
        ce_n(2);                        // PC = 2
        n_chk++; if (ifc.bus_err !== 1'b0) begin n_fail++; $display("FAIL err_pre: got %b exp 0", ifc.bus_err); end
        cyc(AO | CO | BI);
        n_chk++; if (ifc.bus_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b exp 1", ifc.bus_err); end
        sb.push_back(8'h00); peek(EO | SU, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL conflict_b_sub: got %h exp %h", v, e); end
        sb.push_back(8'hEE); peek(EO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL conflict_b_add: got %h exp %h", v, e); end
        cyc(16'h0);
        n_chk++; if (ifc.bus_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b exp 1", ifc.bus_err); end
    endtask

    task automatic test_halt;
        sb.push_back(8'h77);
        cyc(HLT | AO | OI);
        e = sb.pop_front();
        n_chk++; if (ifc.out_value !== e || ifc.out_valid !== 1'b1 || ifc.halted !== 1'b1)
            begin n_fail++; $display("FAIL halt_edge: got val=%h vld=%b hlt=%b exp val=%h vld=1 hlt=1", ifc.out_value, ifc.out_valid, ifc.halted, e); end
        cyc(AI | CE | OI);
        n_chk++; if (ifc.out_value !== 8'h77 || ifc.out_valid !== 1'b0 || ifc.halted !== 1'b1)
            begin n_fail++; $display("FAIL halt_ignore: got val=%h vld=%b hlt=%b exp val=77 vld=0 hlt=1", ifc.out_value, ifc.out_valid, ifc.halted); end
        prog(4'h9, 8'h3C);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_chk++; if (ifc.halted !== 1'b0 || ifc.out_value !== 8'h00 || ifc.bus_err !== 1'b0)
            begin n_fail++; $display("FAIL async_reset: got hlt=%b val=%h err=%b exp 0/00/0", ifc.halted, ifc.out_value, ifc.bus_err); end
        @(negedge clk);
        reset = 1'b1;
        ce_n(9);
        cyc(CO | MI);
        sb.push_back(8'h3C); peek(RO, v); e = sb.pop_front();
        n_chk++; if (v !== e) begin n_fail++; $display("FAIL halt_prog_write: got %h exp %h", v, e); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_lda_add_out();
        test_prog_conflict();
        test_sub();
        test_pc_wrap();
        test_conflict();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
